ysyx_23060025_axi_arbiter: RTL and testbench
============================================

Name: ysyx_23060025_axi_arbiter

Overview:
- Sits directly downstream of the CPU core. Consumes its instruction-fetch port (icache refill, burst reads) and its data port (LSU, single-beat read/write).
- Arbitrates the two ports onto one AXI4 master interface toward the SoC crossbar.
- Returns read data, write completion and the last-beat indication to the requesting port.
- Transfers one transaction at a time; nothing is outstanding across ports.

Parameters:
- ADDR_WIDTH, 32, address width of both request ports and AXI.
- DATA_WIDTH, 32, data width (strobe width = DATA_WIDTH/8).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high (clock, reset).
  - clock  in  1  system clock
  - reset  in  1  asynchronous active-high reset
- Instruction port (from icache):
  - inst_paddr  in  ADDR_WIDTH  burst start address
  - inst_psel  in  1  request, held until final completion
  - inst_plen  in  8  AXI len (beats-1)
  - inst_psize  in  3  AXI size
  - inst_prdata  out  DATA_WIDTH  read beat data
  - inst_pvalid  out  1  beat-valid pulse
  - inst_plast  out  1  final beat, qualified by inst_pvalid
- Data port (from LSU):
  - data_paddr  in  ADDR_WIDTH  address
  - data_psel  in  1  request, held until completion
  - data_pwrite  in  1  1=write
  - data_psize  in  3  AXI size
  - data_pwdata  in  DATA_WIDTH  write data
  - data_pwstrb  in  DATA_WIDTH/8  write strobe
  - data_prdata  out  DATA_WIDTH  read data
  - data_pvalid  out  1  completion pulse
- Status:
  - resp_err  out  1  pulse with any completion whose RRESP/BRESP != 0
- AXI read address: m_araddr out ADDR_WIDTH, m_arlen out 8, m_arsize out 3, m_arburst out 2, m_arvalid out 1, m_arready in 1
- AXI read data: m_rdata in DATA_WIDTH, m_rresp in 2, m_rlast in 1, m_rvalid in 1, m_rready out 1
- AXI write: m_awaddr out ADDR_WIDTH, m_awsize out 3, m_awvalid out 1, m_awready in 1, m_wdata out DATA_WIDTH, m_wstrb out DATA_WIDTH/8, m_wlast out 1, m_wvalid out 1, m_wready in 1
- AXI write response: m_bresp in 2, m_bvalid in 1, m_bready out 1

Behaviour:
- Reset: state IDLE. All valid/ready/pulse outputs are 0. prdata outputs, address, len, size and strobe registers are 0.
- States and transitions:
  - IDLE → I_AR / D_AR / D_AW.
  - I_AR → I_R.
  - D_AR → D_R.
  - D_AW → D_B.
  - I_R, D_R, D_B → IDLE.
- Arbitration (IDLE, per cycle):
  - Data port has fixed priority over the instruction port when both psel are high.
  - The winner's request fields are latched into registers on the grant edge. AXI outputs are driven only from these registers; port inputs may change after grant.
- Grant edge N → AXI valid asserted at N+1.
- I_AR:
  - m_arvalid=1, m_arlen=latched plen, m_arsize=latched psize, m_arburst=INCR (2'b01).
  - On m_arready go to I_R.
  - m_arvalid stays high and the address stays stable until the handshake.
- D_AR: same as I_AR with m_arlen=0, m_arburst=INCR.
- I_R / D_R:
  - m_rready=1.
  - Each R handshake registers rdata into the port's prdata and pulses the port's pvalid the following cycle.
  - Instruction port: inst_plast=m_rlast of that beat.
  - On the beat with m_rlast=1, go to IDLE.
  - Beat count is not checked; m_rlast alone terminates.
- D_AW:
  - m_awvalid=1 and m_wvalid=1 asserted together, m_wlast=1.
  - Each valid drops independently after its own handshake (either order, or the same cycle).
  - Go to D_B when both have completed.
- D_B:
  - m_bready=1.
  - On B handshake, data_pvalid pulses the next cycle and the state goes to IDLE.
  - data_prdata is unchanged by writes.
- resp_err: registered OR of the response bits. It pulses in the same cycle as the pvalid it belongs to, and on every erroneous beat of a burst.
- Hold-off: a port's psel is ignored in the cycle its final completion pulse is high. The requester drops psel or presents its next request from that cycle on. Minimum IDLE→IDLE turnaround for a zero-wait single read is 4 cycles.
- Back-pressure: m_arready, m_awready, m_wready, m_rvalid and m_bvalid may stall indefinitely. All outputs hold steady; no timeout.
- Reset mid-operation: returns to IDLE immediately and drops all valids. Any in-flight AXI transaction is abandoned; the SoC slave shares the same reset.

Test Plan:
1. Instruction burst: inst_psel=1, paddr=0x3000_0000, plen=3, psize=2; memory returns 0x11,0x22,0x33,0x44 with zero wait.
   - Expect arlen=3, arburst=01.
   - Expect four inst_pvalid pulses carrying those words; inst_plast only on 0x44.
   - Expect return to IDLE.
2. Data read: data_psel=1, pwrite=0, paddr=0x8000_0010; slave holds arready=0 for 3 cycles, then rdata=0xDEADBEEF.
   - Expect araddr stable for 4 cycles, arlen=0.
   - Expect data_pvalid once with prdata=0xDEADBEEF.
3. Data write: pwdata=0xA5A5A5A5, pwstrb=4'b0011.
   - Case a: wready 2 cycles before awready.
   - Case b: awready and wready in the same cycle.
   - Expect wstrb=0011, wlast=1, each valid dropping after its own handshake, bready, then one data_pvalid.
4. Simultaneous requests: inst_psel and data_psel rise in the same cycle.
   - Expect the data transaction first, then the instruction burst.
   - Expect no re-grant of data during its completion-pulse cycle.
5. Error response: data read returns rresp=2'b10.
   - Expect resp_err=1 in the same cycle as data_pvalid.
   - Expect resp_err=0 on the next OKAY transaction.
6. Reset mid-burst: assert reset after beat 2 of a 4-beat burst.
   - Expect all valids and pulses 0 asynchronously.
   - After release, expect IDLE, and a new inst request to issue a fresh AR.

Source files
------------

// File: rtl/ysyx_23060025_axi_arbiter.sv
// Arbitrates the icache burst-read port and the LSU single-beat port onto one
// AXI4 master, one transaction at a time, with the data port having priority.
module ysyx_23060025_axi_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  // instruction port
  input  logic [ADDR_WIDTH-1:0]   inst_paddr,
  input  logic                    inst_psel,
  input  logic [7:0]              inst_plen,
  input  logic [2:0]              inst_psize,
  output logic [DATA_WIDTH-1:0]   inst_prdata,
  output logic                    inst_pvalid,
  output logic                    inst_plast,
  // data port
  input  logic [ADDR_WIDTH-1:0]   data_paddr,
  input  logic                    data_psel,
  input  logic                    data_pwrite,
  input  logic [2:0]              data_psize,
  input  logic [DATA_WIDTH-1:0]   data_pwdata,
  input  logic [DATA_WIDTH/8-1:0] data_pwstrb,
  output logic [DATA_WIDTH-1:0]   data_prdata,
  output logic                    data_pvalid,
  // status
  output logic                    resp_err,
  // AXI read address
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  // AXI read data
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  // AXI write address / data
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awsize,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  // AXI write response
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_AR = 3'd1,
    I_R  = 3'd2,
    D_AR = 3'd3,
    D_R  = 3'd4,
    D_AW = 3'd5,
    D_B  = 3'd6
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [7:0]              len_reg, len_next;
  logic [2:0]              size_reg, size_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [STRB_WIDTH-1:0]   wstrb_reg, wstrb_next;
  logic                    aw_done_reg, aw_done_next;
  logic                    w_done_reg, w_done_next;
  logic [DATA_WIDTH-1:0]   inst_prdata_reg, inst_prdata_next;
  logic                    inst_pvalid_reg, inst_pvalid_next;
  logic                    inst_plast_reg, inst_plast_next;
  logic [DATA_WIDTH-1:0]   data_prdata_reg, data_prdata_next;
  logic                    data_pvalid_reg, data_pvalid_next;
  logic                    resp_err_reg, resp_err_next;

  logic inst_req;
  logic data_req;
  logic aw_hs;
  logic w_hs;

  // A requester still sees its own final completion pulse this cycle, so its
  // psel is not yet meaningful for a new request.
  assign data_req = data_psel & ~data_pvalid_reg;
  assign inst_req = inst_psel & ~(inst_pvalid_reg & inst_plast_reg);

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      len_reg         <= '0;
      size_reg        <= '0;
      wdata_reg       <= '0;
      wstrb_reg       <= '0;
      aw_done_reg     <= 1'b0;
      w_done_reg      <= 1'b0;
      inst_prdata_reg <= '0;
      inst_pvalid_reg <= 1'b0;
      inst_plast_reg  <= 1'b0;
      data_prdata_reg <= '0;
      data_pvalid_reg <= 1'b0;
      resp_err_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      len_reg         <= len_next;
      size_reg        <= size_next;
      wdata_reg       <= wdata_next;
      wstrb_reg       <= wstrb_next;
      aw_done_reg     <= aw_done_next;
      w_done_reg      <= w_done_next;
      inst_prdata_reg <= inst_prdata_next;
      inst_pvalid_reg <= inst_pvalid_next;
      inst_plast_reg  <= inst_plast_next;
      data_prdata_reg <= data_prdata_next;
      data_pvalid_reg <= data_pvalid_next;
      resp_err_reg    <= resp_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    len_next         = len_reg;
    size_next        = size_reg;
    wdata_next       = wdata_reg;
    wstrb_next       = wstrb_reg;
    aw_done_next     = aw_done_reg;
    w_done_next      = w_done_reg;
    inst_prdata_next = inst_prdata_reg;
    inst_pvalid_next = 1'b0;
    inst_plast_next  = 1'b0;
    data_prdata_next = data_prdata_reg;
    data_pvalid_next = 1'b0;
    resp_err_next    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (data_req) begin
          addr_next = data_paddr;
          len_next  = 8'd0;
          size_next = data_psize;
          if (data_pwrite) begin
            wdata_next   = data_pwdata;
            wstrb_next   = data_pwstrb;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = D_AW;
          end else begin
            state_next = D_AR;
          end
        end else if (inst_req) begin
          addr_next  = inst_paddr;
          len_next   = inst_plen;
          size_next  = inst_psize;
          state_next = I_AR;
        end
      end
      I_AR: begin
        if (m_arready) state_next = I_R;
      end
      D_AR: begin
        if (m_arready) state_next = D_R;
      end
      I_R: begin
        if (m_rvalid) begin
          inst_prdata_next = m_rdata;
          inst_pvalid_next = 1'b1;
          inst_plast_next  = m_rlast;
          resp_err_next    = |m_rresp;
          if (m_rlast) state_next = IDLE;
        end
      end
      D_R: begin
        if (m_rvalid) begin
          data_prdata_next = m_rdata;
          data_pvalid_next = 1'b1;
          resp_err_next    = |m_rresp;
          if (m_rlast) state_next = IDLE;
        end
      end
      D_AW: begin
        // AW and W complete independently; leave only once both have gone.
        aw_done_next = aw_done_reg | aw_hs;
        w_done_next  = w_done_reg | w_hs;
        if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) state_next = D_B;
      end
      D_B: begin
        if (m_bvalid) begin
          data_pvalid_next = 1'b1;
          resp_err_next    = |m_bresp;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_araddr  = addr_reg;
  assign m_arlen   = len_reg;
  assign m_arsize  = size_reg;
  assign m_arburst = 2'b01;
  assign m_arvalid = (state_reg == I_AR) || (state_reg == D_AR);
  assign m_rready  = (state_reg == I_R) || (state_reg == D_R);

  assign m_awaddr  = addr_reg;
  assign m_awsize  = size_reg;
  assign m_awvalid = (state_reg == D_AW) && !aw_done_reg;
  assign m_wdata   = wdata_reg;
  assign m_wstrb   = wstrb_reg;
  assign m_wvalid  = (state_reg == D_AW) && !w_done_reg;
  assign m_wlast   = m_wvalid;
  assign m_bready  = (state_reg == D_B);

  assign inst_prdata = inst_prdata_reg;
  assign inst_pvalid = inst_pvalid_reg;
  assign inst_plast  = inst_plast_reg;
  assign data_prdata = data_prdata_reg;
  assign data_pvalid = data_pvalid_reg;
  assign resp_err    = resp_err_reg;

endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// Directed bench: a main process plays requester and AXI slave and queues the
// expected port completions; a monitor pops and checks them as they appear.
module tb_ysyx_23060025_axi_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] inst_paddr;
  logic          inst_psel;
  logic [7:0]    inst_plen;
  logic [2:0]    inst_psize;
  logic [DW-1:0] inst_prdata;
  logic          inst_pvalid;
  logic          inst_plast;
  logic [AW-1:0] data_paddr;
  logic          data_psel;
  logic          data_pwrite;
  logic [2:0]    data_psize;
  logic [DW-1:0] data_pwdata;
  logic [3:0]    data_pwstrb;
  logic [DW-1:0] data_prdata;
  logic          data_pvalid;
  logic          resp_err;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_arvalid;
  logic          m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          m_rvalid;
  logic          m_rready;
  logic [AW-1:0] m_awaddr;
  logic [2:0]    m_awsize;
  logic          m_awvalid;
  logic          m_awready;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_wlast;
  logic          m_wvalid;
  logic          m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid;
  logic          m_bready;

  always #5 clock = ~clock;

  ysyx_23060025_axi_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .inst_paddr(inst_paddr), .inst_psel(inst_psel), .inst_plen(inst_plen),
    .inst_psize(inst_psize), .inst_prdata(inst_prdata), .inst_pvalid(inst_pvalid),
    .inst_plast(inst_plast),
    .data_paddr(data_paddr), .data_psel(data_psel), .data_pwrite(data_pwrite),
    .data_psize(data_psize), .data_pwdata(data_pwdata), .data_pwstrb(data_pwstrb),
    .data_prdata(data_prdata), .data_pvalid(data_pvalid),
    .resp_err(resp_err),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  typedef struct packed {
    logic          port;   // 0 = inst, 1 = data
    logic [DW-1:0] data;
    logic          last;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every completion pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (inst_pvalid || data_pvalid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pvalid actual inst=%0b data=%0b required none",
                   inst_pvalid, data_pvalid);
        end else begin
          mon_e = sb.pop_front();
          chk("pvalid_port", {31'd0, data_pvalid}, {31'd0, mon_e.port});
          chk("pvalid_both", {31'd0, inst_pvalid & data_pvalid}, 32'd0);
          chk("prdata", mon_e.port ? data_prdata : inst_prdata, mon_e.data);
          if (!mon_e.port) chk("plast", {31'd0, inst_plast}, {31'd0, mon_e.last});
          chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
          $display("txn %s data=0x%08h last=%0b err=%0b",
                   mon_e.port ? "data" : "inst", mon_e.port ? data_prdata : inst_prdata,
                   inst_plast, resp_err);
        end
      end else if (resp_err) begin
        chk("resp_err_without_pvalid", {31'd0, resp_err}, 32'd0);
      end
    end
  end

  task automatic ar_accept(input int stall, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size);
    int n = 0;
    while (!m_arvalid && n < 20) begin
      step();
      n++;
    end
    chk("ar_latency", n, 1);
    chk("arvalid", {31'd0, m_arvalid}, 32'd1);
    if (!m_arvalid) return;
    chk("araddr", m_araddr, addr);
    chk("arlen", {24'd0, m_arlen}, {24'd0, len});
    chk("arsize", {29'd0, m_arsize}, {29'd0, size});
    chk("arburst", {30'd0, m_arburst}, 32'd1);
    repeat (stall) begin
      step();
      chk("arvalid_hold", {31'd0, m_arvalid}, 32'd1);
      chk("araddr_hold", m_araddr, addr);
    end
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    chk("arvalid_drop", {31'd0, m_arvalid}, 32'd0);
  endtask

  task automatic rbeat(input logic port, input logic [31:0] data, input logic last,
                       input logic [1:0] resp);
    chk("rready", {31'd0, m_rready}, 32'd1);
    m_rvalid = 1'b1;
    m_rdata  = data;
    m_rlast  = last;
    m_rresp  = resp;
    sb.push_back('{port: port, data: data, last: last, err: (resp != 2'b00)});
    if (port) last_rd = data;
    step();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rresp  = 2'b00;
  endtask

  task automatic data_read(input logic [31:0] addr, input int stall,
                           input logic [31:0] rdata, input logic [1:0] resp);
    data_psel   = 1'b1;
    data_pwrite = 1'b0;
    data_paddr  = addr;
    data_psize  = 3'd2;
    ar_accept(stall, addr, 8'd0, 3'd2);
    rbeat(1'b1, rdata, 1'b1, resp);
    data_psel = 1'b0;
    step();
  endtask

  task automatic data_write(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int aw_at, input int w_at);
    int  n = 0;
    bit  aw_done = 0;
    bit  w_done = 0;
    int  last_c;
    data_psel   = 1'b1;
    data_pwrite = 1'b1;
    data_paddr  = addr;
    data_psize  = 3'd2;
    data_pwdata = wdata;
    data_pwstrb = wstrb;
    while (!m_awvalid && n < 20) begin
      step();
      n++;
    end
    chk("aw_latency", n, 1);
    chk("awaddr", m_awaddr, addr);
    chk("awsize", {29'd0, m_awsize}, 32'd2);
    chk("wdata", m_wdata, wdata);
    chk("wstrb", {28'd0, m_wstrb}, {28'd0, wstrb});
    last_c = (aw_at > w_at) ? aw_at : w_at;
    for (int c = 0; c <= last_c; c++) begin
      chk("awvalid", {31'd0, m_awvalid}, {31'd0, !aw_done});
      chk("wvalid", {31'd0, m_wvalid}, {31'd0, !w_done});
      chk("wlast", {31'd0, m_wlast}, {31'd0, !w_done});
      m_awready = (c == aw_at);
      m_wready  = (c == w_at);
      step();
      if (c == aw_at) aw_done = 1;
      if (c == w_at) w_done = 1;
      m_awready = 1'b0;
      m_wready  = 1'b0;
    end
    chk("awvalid_done", {31'd0, m_awvalid}, 32'd0);
    chk("wvalid_done", {31'd0, m_wvalid}, 32'd0);
    chk("bready", {31'd0, m_bready}, 32'd1);
    step();
    chk("bready_stall", {31'd0, m_bready}, 32'd1);
    m_bvalid = 1'b1;
    m_bresp  = 2'b00;
    sb.push_back('{port: 1'b1, data: last_rd, last: 1'b0, err: 1'b0});
    step();
    m_bvalid    = 1'b0;
    data_psel   = 1'b0;
    data_pwrite = 1'b0;
    step();
    chk("bready_idle", {31'd0, m_bready}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    inst_paddr = '0; inst_psel = 1'b0; inst_plen = '0; inst_psize = '0;
    data_paddr = '0; data_psel = 1'b0; data_pwrite = 1'b0; data_psize = '0;
    data_pwdata = '0; data_pwstrb = '0;
    m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;

    repeat (3) step();
    chk("rst_arvalid", {31'd0, m_arvalid}, 32'd0);
    chk("rst_awvalid", {31'd0, m_awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, m_wvalid}, 32'd0);
    chk("rst_rready", {31'd0, m_rready}, 32'd0);
    chk("rst_bready", {31'd0, m_bready}, 32'd0);
    chk("rst_inst_pvalid", {31'd0, inst_pvalid}, 32'd0);
    chk("rst_data_pvalid", {31'd0, data_pvalid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_inst_prdata", inst_prdata, 32'd0);
    chk("rst_data_prdata", data_prdata, 32'd0);
    chk("rst_araddr", m_araddr, 32'd0);
    chk("rst_arlen", {24'd0, m_arlen}, 32'd0);
    chk("rst_wstrb", {28'd0, m_wstrb}, 32'd0);
    reset = 1'b0;
    step();

    // 1: instruction burst of four zero-wait beats
    inst_psel = 1'b1; inst_paddr = 32'h3000_0000; inst_plen = 8'd3; inst_psize = 3'd2;
    ar_accept(0, 32'h3000_0000, 8'd3, 3'd2);
    rbeat(1'b0, 32'h11, 1'b0, 2'b00);
    rbeat(1'b0, 32'h22, 1'b0, 2'b00);
    rbeat(1'b0, 32'h33, 1'b0, 2'b00);
    rbeat(1'b0, 32'h44, 1'b1, 2'b00);
    inst_psel = 1'b0;
    step();
    chk("t1_idle_arvalid", {31'd0, m_arvalid}, 32'd0);
    chk("t1_idle_rready", {31'd0, m_rready}, 32'd0);

    // 2: data read with three cycles of AR back-pressure
    data_read(32'h8000_0010, 3, 32'hDEAD_BEEF, 2'b00);

    // 3: writes, W before AW and then both together
    data_write(32'h8000_0020, 32'hA5A5_A5A5, 4'b0011, 2, 0);
    data_write(32'h8000_0024, 32'h5A5A_5A5A, 4'b1100, 1, 1);

    // 4: simultaneous requests; data wins, and its held psel is ignored
    // during its completion pulse so the instruction port is granted next
    data_psel = 1'b1; data_pwrite = 1'b0; data_paddr = 32'h8000_0040; data_psize = 3'd2;
    inst_psel = 1'b1; inst_paddr = 32'h3000_1000; inst_plen = 8'd1; inst_psize = 3'd2;
    ar_accept(0, 32'h8000_0040, 8'd0, 3'd2);
    rbeat(1'b1, 32'h1234_5678, 1'b1, 2'b00);
    ar_accept(0, 32'h3000_1000, 8'd1, 3'd2);
    data_psel = 1'b0;
    rbeat(1'b0, 32'h0000_AAA1, 1'b0, 2'b00);
    rbeat(1'b0, 32'h0000_AAA2, 1'b1, 2'b00);
    inst_psel = 1'b0;
    step();

    // 5: SLVERR read followed by an OKAY read
    data_read(32'h8000_0050, 0, 32'hBAD0_BAD0, 2'b10);
    data_read(32'h8000_0054, 1, 32'h0000_C0DE, 2'b00);

    // 6: reset in the middle of a burst, then a fresh request
    inst_psel = 1'b1; inst_paddr = 32'h3000_2000; inst_plen = 8'd3; inst_psize = 3'd2;
    ar_accept(0, 32'h3000_2000, 8'd3, 3'd2);
    rbeat(1'b0, 32'hAAAA_0001, 1'b0, 2'b00);
    rbeat(1'b0, 32'hAAAA_0002, 1'b0, 2'b00);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rready_async", {31'd0, m_rready}, 32'd0);
    chk("t6_inst_pvalid_async", {31'd0, inst_pvalid}, 32'd0);
    chk("t6_arvalid_async", {31'd0, m_arvalid}, 32'd0);
    chk("t6_inst_prdata_async", inst_prdata, 32'd0);
    step();
    reset = 1'b0;
    ar_accept(0, 32'h3000_2000, 8'd3, 3'd2);
    rbeat(1'b0, 32'hBBBB_0001, 1'b0, 2'b00);
    rbeat(1'b0, 32'hBBBB_0002, 1'b0, 2'b00);
    rbeat(1'b0, 32'hBBBB_0003, 1'b0, 2'b00);
    rbeat(1'b0, 32'hBBBB_0004, 1'b1, 2'b00);
    inst_psel = 1'b0;
    repeat (3) step();
    chk("t6_idle_arvalid", {31'd0, m_arvalid}, 32'd0);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
